// File: rtl/tlc_pkg.sv
// Shared encodings and helpers for the N-way traffic light controller.
package tlc_pkg;

    typedef enum logic [1:0] {
        PH_GREEN   = 2'b00,
        PH_YELLOW  = 2'b01,
        PH_ALL_RED = 2'b10,
        PH_FLASH   = 2'b11
    } phase_t;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;

    // A single approach still needs a one-bit index.
    function automatic int way_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tlc_nway_if.sv
// Sensor/flash inputs and lamp/status outputs of the controller.
interface tlc_nway_if
    import tlc_pkg::*;
#(
    parameter int N_WAYS = 2
);
    localparam int WAY_W = way_width(N_WAYS);

    logic [N_WAYS-1:0]   sensor;
    logic                flash;
    logic [2*N_WAYS-1:0] lights;
    logic [WAY_W-1:0]    green_way;
    logic [1:0]          phase;

    modport master (
        output sensor, flash,
        input  lights, green_way, phase
    );

    modport slave (
        input  sensor, flash,
        output lights, green_way, phase
    );
endinterface

// File: rtl/tlc_rr_pick.sv
// Round-robin search for the next demanding way after cur; valid flags other demand.
module tlc_rr_pick #(
    parameter int N_WAYS = 2,
    parameter int WAY_W  = 1
) (
    input  logic [N_WAYS-1:0] sensor,
    input  logic [WAY_W-1:0]  cur,
    output logic [WAY_W-1:0]  next_idx,
    output logic              valid
);

    // Walk from farthest to nearest so the nearest demanding way wins.
    always_comb begin
        next_idx = '0;
        valid    = 1'b0;
        for (int k = N_WAYS - 1; k >= 1; k--) begin
            if (sensor[(int'(cur) + k) % N_WAYS]) begin
                next_idx = WAY_W'((int'(cur) + k) % N_WAYS);
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tlc_nway.sv
// N-approach round-robin traffic light controller with min/max green and flash mode.
//
// state      | meaning
// PH_GREEN   | way cur green, held for demand between MIN_GREEN and MAX_GREEN
// PH_YELLOW  | way cur yellow for YELLOW_TIME cycles
// PH_ALL_RED | all ways red for ALL_RED_TIME cycles, then serve next_way
// PH_FLASH   | maintenance: all ways blink yellow/red every FLASH_HALF cycles
module tlc_nway
    import tlc_pkg::*;
#(
    parameter int N_WAYS       = 2,
    parameter int TIMER_W      = 8,
    parameter int MIN_GREEN    = 4,
    parameter int MAX_GREEN    = 16,
    parameter int YELLOW_TIME  = 2,
    parameter int ALL_RED_TIME = 1,
    parameter int FLASH_HALF   = 4
) (
    input  logic        clk,
    input  logic        reset,
    tlc_nway_if.slave   bus
);
    localparam int WAY_W = way_width(N_WAYS);

    localparam logic [TIMER_W-1:0] T_MIN_GREEN = TIMER_W'(MIN_GREEN - 1);
    localparam logic [TIMER_W-1:0] T_MAX_GREEN = TIMER_W'(MAX_GREEN - 1);
    localparam logic [TIMER_W-1:0] T_YELLOW    = TIMER_W'(YELLOW_TIME - 1);
    localparam logic [TIMER_W-1:0] T_ALL_RED   = TIMER_W'(ALL_RED_TIME - 1);
    localparam logic [TIMER_W-1:0] T_FLASH     = TIMER_W'(FLASH_HALF - 1);

    phase_t              phase_q;
    logic [WAY_W-1:0]    cur;
    logic [WAY_W-1:0]    next_way;
    logic [TIMER_W-1:0]  timer;
    logic                flash_on;

    logic [TIMER_W-1:0]  timer_inc;
    logic [WAY_W-1:0]    pick_idx;
    logic                other_demand;
    logic                green_done;
    logic [2*N_WAYS-1:0] lights_d;

    tlc_rr_pick #(
        .N_WAYS (N_WAYS),
        .WAY_W  (WAY_W)
    ) u_pick (
        .sensor   (bus.sensor),
        .cur      (cur),
        .next_idx (pick_idx),
        .valid    (other_demand)
    );

    assign timer_inc = (timer == '1) ? timer : timer + 1'b1;

    // Own demand holds green only until MAX_GREEN; without rivals green never ends.
    assign green_done = (timer >= T_MIN_GREEN) && other_demand &&
                        (!bus.sensor[cur] || (timer >= T_MAX_GREEN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q  <= PH_GREEN;
            cur      <= '0;
            next_way <= '0;
            timer    <= '0;
            flash_on <= 1'b0;
        end else if (bus.flash) begin
            phase_q <= PH_FLASH;
            if (phase_q != PH_FLASH) begin
                flash_on <= 1'b1;
                timer    <= '0;
            end else if (timer == T_FLASH) begin
                flash_on <= ~flash_on;
                timer    <= '0;
            end else begin
                timer <= timer_inc;
            end
        end else begin
            case (phase_q)
                PH_GREEN: begin
                    if (green_done) begin
                        next_way <= pick_idx;
                        phase_q  <= PH_YELLOW;
                        timer    <= '0;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                PH_YELLOW: begin
                    if (timer == T_YELLOW) begin
                        phase_q <= PH_ALL_RED;
                        timer   <= '0;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                PH_ALL_RED: begin
                    if (timer == T_ALL_RED) begin
                        cur     <= next_way;
                        phase_q <= PH_GREEN;
                        timer   <= '0;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                PH_FLASH: begin
                    // Leaving maintenance always restarts service at way 0.
                    next_way <= '0;
                    flash_on <= 1'b0;
                    phase_q  <= PH_ALL_RED;
                    timer    <= '0;
                end
                default: begin
                    phase_q <= PH_ALL_RED;
                    timer   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        lights_d = '0;
        for (int i = 0; i < N_WAYS; i++) begin
            case (phase_q)
                PH_GREEN:  lights_d[2*i +: 2] = (WAY_W'(i) == cur) ? LAMP_GREEN : LAMP_RED;
                PH_YELLOW: lights_d[2*i +: 2] = (WAY_W'(i) == cur) ? LAMP_YELLOW : LAMP_RED;
                PH_FLASH:  lights_d[2*i +: 2] = flash_on ? LAMP_YELLOW : LAMP_RED;
                default:   lights_d[2*i +: 2] = LAMP_RED;
            endcase
        end
    end

    assign bus.lights    = lights_d;
    assign bus.green_way = cur;
    assign bus.phase     = phase_q;

endmodule
